tdc_timestamp_encoder: RTL and testbench
========================================

// Module: tdc_timestamp_encoder
// PURPOSE
//  Sits directly downstream of the TDC multi-phase clock generator.
//  Takes the NPH-bit hit snapshot: the hit signal is sampled by each phase clock and
//  re-registered into the single system clock domain (synchronisation happens outside this block).
//  Detects hit rising edges and encodes the fine bin (popcount) plus a free-running coarse count.
//  Buffers the {coarse, fine} timestamps in a FWFT FIFO with a valid/ready readout.
// PARAMETERS
//  NPH        10  number of phase samples per clk period (fine bins)
//  COARSE_W   22  coarse counter width
//  FIFO_DEPTH 16  timestamp FIFO depth, power of 2, >=4
// PORTS
//  clk        in   1            system clock (same clk that feeds the phase PLLs)
//  rst        in   1            asynchronous, active-low reset
//  arm        in   1            1 = run coarse counter and accept hits
//  phase_smp  in   NPH          per-phase hit samples, registered in clk domain
//  ts_ready   in   1            consumer accepts the head word
//  ts_valid   out  1            FIFO head word valid
//  ts_coarse  out  COARSE_W     head word coarse time
//  ts_fine    out  4            head word fine bin, 0..NPH-1
//  ts_marker  out  1            head word is a coarse-rollover marker (0 unless macro)
//  fifo_level out  $clog2(FIFO_DEPTH)+1  words stored
//  drop_cnt   out  8            saturating count of words lost to FIFO full
//  clr_drop   in   1            synchronous clear of drop_cnt
// BEHAVIOUR
//  - Reset (rst=0, async): all state is cleared.
//    - coarse=0; prev_zero=1; stage empty; FIFO empty.
//    - ts_valid=0; ts_coarse=0; ts_fine=0; ts_marker=0; fifo_level=0; drop_cnt=0.
//  - A reset during operation discards all FIFO contents immediately.
//  - Coarse counter:
//    - arm=0: held at 0.
//    - arm=1: +1 per clk, wraps 2^COARSE_W-1 -> 0.
//  - prev_zero: registered each clk as (phase_smp == 0).
//  - Event in cycle k: arm & prev_zero & (phase_smp != 0).
//    - Two consecutive cycles can never both be events.
//  - fine = NPH - popcount(phase_smp), clipped to 0..NPH-1.
//    - Popcount makes the encoding tolerant to bubbles.
//    - All-ones input gives fine=0.
//  - Event word {coarse(k), fine, marker=0} goes to the stage register at edge k.
//    - It is written to the FIFO at edge k+1.
//    - With an empty FIFO, ts_valid=1 from edge k+1. Latency is 2 clk from the sample edge.
//  - FIFO is first-word-fall-through.
//    - Pop when ts_valid & ts_ready.
//    - Head data stays stable while ts_valid & ~ts_ready.
//  - Push when full with no pop in the same cycle: the word is dropped.
//    - drop_cnt increments and saturates at 255.
//  - Push and pop in the same cycle while full: both complete; level is unchanged.
//  - Push and pop in the same cycle while empty: the word is stored. No bypass: ts_valid=0 that cycle.
//  - clr_drop has priority over a coincident drop increment (result 0).
//  - arm falling: a word already in the stage is still pushed; the FIFO is not flushed.
// CONFIGURATION
//  TDC_ROLLOVER_MARKER_EN
//  - Defined:
//    - When coarse wraps to 0 (arm=1), a marker word {coarse=0, fine=0, marker=1} is pushed.
//    - If an event occupies the stage that cycle, the marker is held pending and staged the next cycle.
//    - It always fits, because events cannot be back to back.
//    - Markers obey the same full/drop rules.
//  - Undefined: no markers; ts_marker is tied to 0; the wrap is silent.
// TESTING
//  1. Reset, arm=1; phase_smp 0 -> 10'h3F0 at coarse=5.
//     Expect one word {coarse=5, fine=4} and ts_valid exactly 2 clk after the sample edge.
//  2. phase_smp held at 10'h3FF for 20 clk.
//     Expect a single word {fine=0}; no further words until phase_smp returns to 0.
//  3. ts_ready=0 with 20 isolated hits (0,nz,0 pattern).
//     Expect fifo_level=16, drop_cnt=4, head stable; after ts_ready=1, 16 words drain in order.
//  4. FIFO full, ts_ready=1, hit pushed in the same cycle.
//     Expect level stays 16, drop_cnt unchanged.
//  5. Assert rst=0 mid-drain with level=7.
//     Expect ts_valid=0, level=0, drop_cnt=0 asynchronously; coarse restarts at 0.
//  6. [TDC_ROLLOVER_MARKER_EN] COARSE_W=4, hit on the wrap cycle.
//     Expect the event word first, then marker {0,0,1} one word later; without the macro, the event word only.

Source files
------------

// File: rtl/tdc_timestamp_encoder.sv
// -----------------------------------------------------------------------------
// tdc_timestamp_encoder
//   Turns the clk-domain snapshot of the multi-phase hit samples into
//   {coarse, fine} timestamps and buffers them in a first-word-fall-through
//   FIFO that is read out with a valid/ready handshake.
//
//   Hit rising edge: the previous snapshot was all zero and the current one is
//   not. fine = NPH - popcount(snapshot), so sampling bubbles do not matter.
//   The event word sits in a one-entry stage register for one clk and is
//   written to the FIFO on the following edge.
//
//   Optional feature, macro TDC_ROLLOVER_MARKER_EN: each coarse wrap to 0
//   (while armed) also produces a marker word {coarse=0, fine=0, marker=1}.
//   Without the macro no word ever carries the marker bit.
//
// Ports
//   i_clk         system clock
//   i_rst         asynchronous reset, active low
//   i_arm         1 = run the coarse counter and accept hits
//   i_phase_smp   NPH phase samples of the hit, already in the clk domain
//   i_ts_ready    consumer accepts the head word
//   o_ts_valid    FIFO head word valid
//   o_ts_coarse   head word coarse time
//   o_ts_fine     head word fine bin, 0..NPH-1
//   o_ts_marker   head word is a coarse-rollover marker
//   o_fifo_level  number of words stored
//   o_drop_cnt    saturating count of words lost to a full FIFO
//   i_clr_drop    synchronous clear of o_drop_cnt (wins over an increment)
// -----------------------------------------------------------------------------
module tdc_timestamp_encoder #(
   parameter int unsigned NPH        = 10,
   parameter int unsigned COARSE_W   = 22,
   parameter int unsigned FIFO_DEPTH = 16
) (
   input  logic                          i_clk,
   input  logic                          i_rst,
   input  logic                          i_arm,
   input  logic [NPH-1:0]                i_phase_smp,
   input  logic                          i_ts_ready,
   output logic                          o_ts_valid,
   output logic [COARSE_W-1:0]           o_ts_coarse,
   output logic [3:0]                    o_ts_fine,
   output logic                          o_ts_marker,
   output logic [$clog2(FIFO_DEPTH):0]   o_fifo_level,
   output logic [7:0]                    o_drop_cnt,
   input  logic                          i_clr_drop
);

   localparam int unsigned AW = $clog2(FIFO_DEPTH);
   localparam int unsigned LW = AW + 1;
   localparam int unsigned CW = $clog2(NPH + 1);

   typedef struct packed {
      logic [COARSE_W-1:0] coarse;
      logic [3:0]          fine;
      logic                marker;
   } ts_word_t;

   logic [COARSE_W-1:0] r_coarse;
   logic                r_prev_zero;
   logic                r_stg_vld;
   ts_word_t            r_stg;
   ts_word_t            r_mem [FIFO_DEPTH];
   logic [AW-1:0]       r_wr_ptr;
   logic [AW-1:0]       r_rd_ptr;
   logic [LW-1:0]       r_count;
   logic [7:0]          r_drop;

   logic [CW-1:0]       w_ones;
   logic [3:0]          w_fine;
   logic                w_event;
   logic                w_stg_vld_nxt;
   ts_word_t            w_stg_nxt;
   logic                w_full;
   logic                w_pop;
   logic                w_wr;
   logic                w_drop;
   ts_word_t            w_head;

`ifdef TDC_ROLLOVER_MARKER_EN
   logic                w_wrap;
   logic                r_mrk_pend;
   logic                w_mrk_pend_nxt;
`endif

   // Popcount of the phase snapshot
   always_comb begin
      w_ones = '0;
      for (int i = 0; i < NPH; i++) begin
         w_ones = w_ones + CW'(i_phase_smp[i]);
      end
   end

   // Fine bin; an empty snapshot never forms an event, it is only clipped here
   assign w_fine  = (w_ones == '0) ? 4'(NPH - 1) : 4'(NPH) - 4'(w_ones);
   assign w_event = i_arm & r_prev_zero & (i_phase_smp != '0);

`ifdef TDC_ROLLOVER_MARKER_EN
   assign w_wrap = i_arm & (r_coarse == '1);
`endif

   // Stage-register next value: event word, else (optionally) a marker
   always_comb begin
      w_stg_vld_nxt = 1'b0;
      w_stg_nxt     = '0;
`ifdef TDC_ROLLOVER_MARKER_EN
      w_mrk_pend_nxt = 1'b0;
      if (w_event) begin
         w_stg_vld_nxt    = 1'b1;
         w_stg_nxt.coarse = r_coarse;
         w_stg_nxt.fine   = w_fine;
         // A wrap coinciding with an event waits one cycle; events never repeat back to back
         w_mrk_pend_nxt   = w_wrap;
      end else if (w_wrap || r_mrk_pend) begin
         w_stg_vld_nxt    = 1'b1;
         w_stg_nxt.marker = 1'b1;
      end
`else
      if (w_event) begin
         w_stg_vld_nxt    = 1'b1;
         w_stg_nxt.coarse = r_coarse;
         w_stg_nxt.fine   = w_fine;
      end
`endif
   end

   // FIFO handshake: a full FIFO still accepts when the head leaves the same cycle
   assign w_full = (r_count == LW'(FIFO_DEPTH));
   assign w_pop  = o_ts_valid & i_ts_ready;
   assign w_wr   = r_stg_vld & (~w_full | w_pop);
   assign w_drop = r_stg_vld & w_full & ~w_pop;

   // Coarse counter, edge detector history, stage, FIFO pointers and drop counter
   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         r_coarse    <= '0;
         r_prev_zero <= 1'b1;
         r_stg_vld   <= 1'b0;
         r_stg       <= '0;
         r_wr_ptr    <= '0;
         r_rd_ptr    <= '0;
         r_count     <= '0;
         r_drop      <= '0;
      end else begin
         r_coarse    <= i_arm ? r_coarse + COARSE_W'(1) : '0;
         r_prev_zero <= (i_phase_smp == '0);
         r_stg_vld   <= w_stg_vld_nxt;
         r_stg       <= w_stg_nxt;
         if (w_wr) begin
            r_wr_ptr <= r_wr_ptr + AW'(1);
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + AW'(1);
         end
         r_count <= r_count + LW'(w_wr) - LW'(w_pop);
         if (i_clr_drop) begin
            r_drop <= '0;
         end else if (w_drop && (r_drop != 8'hFF)) begin
            r_drop <= r_drop + 8'd1;
         end
      end
   end

`ifdef TDC_ROLLOVER_MARKER_EN
   // Pending-marker flag
   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         r_mrk_pend <= 1'b0;
      end else begin
         r_mrk_pend <= w_mrk_pend_nxt;
      end
   end
`endif

   // FIFO storage; contents are meaningless while the count says empty
   always_ff @(posedge i_clk) begin
      if (w_wr) begin
         r_mem[r_wr_ptr] <= r_stg;
      end
   end

   // Head word, forced to zero while empty so reset/empty outputs read 0
   assign w_head       = r_mem[r_rd_ptr];
   assign o_ts_valid   = (r_count != '0);
   assign o_ts_coarse  = o_ts_valid ? w_head.coarse : '0;
   assign o_ts_fine    = o_ts_valid ? w_head.fine   : '0;
   assign o_ts_marker  = o_ts_valid & w_head.marker;
   assign o_fifo_level = r_count;
   assign o_drop_cnt   = r_drop;

endmodule

// File: tb/tb_tdc_timestamp_encoder.sv
// -----------------------------------------------------------------------------
// tb_tdc_timestamp_encoder
//   Directed + randomized bench for tdc_timestamp_encoder. A queue-based
//   reference model tracks the expected FIFO contents and drop count; the
//   outputs are compared one time unit after every rising clk edge. A second
//   instance with a 4-bit coarse counter exercises the rollover behaviour.
//   Honors TDC_ROLLOVER_MARKER_EN to match the build of the design.
// -----------------------------------------------------------------------------
module tb_tdc_timestamp_encoder;

   localparam int unsigned NPH   = 10;
   localparam int unsigned CW    = 22;
   localparam int unsigned DEPTH = 16;
   localparam int unsigned CMASK = (1 << CW) - 1;

   logic            clk = 1'b0;
   logic            rst = 1'b0;
   logic            arm = 1'b0;
   logic [NPH-1:0]  smp = '0;
   logic            ready = 1'b0;
   logic            clr = 1'b0;
   logic            ts_valid;
   logic [CW-1:0]   ts_coarse;
   logic [3:0]      ts_fine;
   logic            ts_marker;
   logic [4:0]      level;
   logic [7:0]      drop;

   logic            s_arm = 1'b0;
   logic [NPH-1:0]  s_smp = '0;
   logic            s_ready = 1'b0;
   logic            s_valid;
   logic [3:0]      s_coarse;
   logic [3:0]      s_fine;
   logic            s_marker;
   logic [4:0]      s_level;
   logic [7:0]      s_drop;

   always #5 clk = ~clk;

   tdc_timestamp_encoder #(.NPH(NPH), .COARSE_W(CW), .FIFO_DEPTH(DEPTH)) u_dut (
      .i_clk(clk), .i_rst(rst), .i_arm(arm), .i_phase_smp(smp), .i_ts_ready(ready),
      .o_ts_valid(ts_valid), .o_ts_coarse(ts_coarse), .o_ts_fine(ts_fine),
      .o_ts_marker(ts_marker), .o_fifo_level(level), .o_drop_cnt(drop), .i_clr_drop(clr)
   );

   tdc_timestamp_encoder #(.NPH(NPH), .COARSE_W(4), .FIFO_DEPTH(DEPTH)) u_small (
      .i_clk(clk), .i_rst(rst), .i_arm(s_arm), .i_phase_smp(s_smp), .i_ts_ready(s_ready),
      .o_ts_valid(s_valid), .o_ts_coarse(s_coarse), .o_ts_fine(s_fine),
      .o_ts_marker(s_marker), .o_fifo_level(s_level), .o_drop_cnt(s_drop), .i_clr_drop(1'b0)
   );

   // Reference model: timestamps as plain integers, FIFO as a queue
   typedef struct {
      int unsigned coarse;
      int unsigned fine;
      bit          marker;
   } mword_t;

   mword_t      m_q[$];
   mword_t      m_stg;
   bit          m_stg_v;
   bit          m_prev_zero;
   int unsigned m_coarse;
   int unsigned m_drop;
   int unsigned seen[$];
   int          n_vec = 0;
   int          n_err = 0;

   task automatic model_reset();
      m_q.delete();
      m_stg_v     = 1'b0;
      m_stg       = '{0, 0, 1'b0};
      m_prev_zero = 1'b1;
      m_coarse    = 0;
      m_drop      = 0;
   endtask

   // One clk edge of the main instance, from the input values before the edge
   task automatic model_edge();
      if (m_q.size() != 0 && ready) void'(m_q.pop_front());
      if (m_stg_v) begin
         if (m_q.size() < DEPTH) m_q.push_back(m_stg);
         else if (m_drop < 255) m_drop++;
      end
      if (clr) m_drop = 0;
      // The main instance never reaches its coarse wrap, so no markers appear here
      m_stg_v = arm && m_prev_zero && (smp != 0);
      if (m_stg_v) m_stg = '{m_coarse, NPH - $countones(smp), 1'b0};
      m_coarse    = arm ? ((m_coarse + 1) & CMASK) : 0;
      m_prev_zero = (smp == 0);
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_all();
      mword_t h;
      h = (m_q.size() != 0) ? m_q[0] : '{0, 0, 1'b0};
      chk("valid",  32'(ts_valid),  32'(m_q.size() != 0));
      chk("level",  32'(level),     32'(m_q.size()));
      chk("drop",   32'(drop),      m_drop);
      chk("coarse", 32'(ts_coarse), h.coarse);
      chk("fine",   32'(ts_fine),   h.fine);
      chk("marker", 32'(ts_marker), 32'(h.marker));
   endtask

   // Advance one clk; inputs are changed by the caller after this returns
   task automatic step();
      if (ts_valid && ready) seen.push_back(32'(ts_fine));
      @(posedge clk);
      model_edge();
      #1;
      check_all();
   endtask

   task automatic hit(input logic [NPH-1:0] v);
      smp = v;
      step();
      smp = '0;
      step();
   endtask

   int unsigned h0;

   initial begin
      model_reset();
      #1;
      chk("rst_valid",  32'(ts_valid),  0);
      chk("rst_coarse", 32'(ts_coarse), 0);
      chk("rst_level",  32'(level),     0);
      chk("rst_drop",   32'(drop),      0);
      @(posedge clk);
      #1;
      rst = 1'b1;

      // T1: single hit at coarse 5, word visible two edges after the sample
      arm = 1'b1;
      while (m_coarse != 5) step();
      smp = 10'h3F0;
      step();
      chk("t1_not_yet", 32'(ts_valid), 0);
      smp = '0;
      step();
      chk("t1_valid",  32'(ts_valid),  1);
      chk("t1_coarse", 32'(ts_coarse), 5);
      chk("t1_fine",   32'(ts_fine),   4);

      // T2: all-ones held for 20 clk yields exactly one fine=0 word
      ready = 1'b1;
      step();
      seen.delete();
      smp = 10'h3FF;
      repeat (20) step();
      smp = '0;
      repeat (4) step();
      chk("t2_nwords", seen.size(), 1);
      chk("t2_fine", (seen.size() > 0) ? seen[0] : 32'hFFFF, 0);
      ready = 1'b0;

      // T3: 20 isolated hits into a stalled FIFO, then drain in order
      h0 = m_coarse;
      for (int i = 0; i < 20; i++) hit(NPH'($urandom_range(1, 1023)));
      step();
      chk("t3_level", 32'(level), 16);
      chk("t3_drop",  32'(drop),  4);
      chk("t3_head",  32'(ts_coarse), h0);
      seen.delete();
      ready = 1'b1;
      repeat (16) step();
      chk("t3_drained", seen.size(), 16);
      chk("t3_empty", 32'(level), 0);
      ready = 1'b0;

      // T4: push and pop on the same edge while full
      for (int i = 0; i < 16; i++) hit(NPH'($urandom_range(1, 1023)));
      smp = 10'h001;
      step();
      smp = '0;
      ready = 1'b1;
      step();
      ready = 1'b0;
      chk("t4_level", 32'(level), 16);
      chk("t4_drop",  32'(drop),  4);
      // clear coinciding with a drop gives 0, then a plain drop counts 1
      smp = 10'h003;
      step();
      smp = '0;
      clr = 1'b1;
      step();
      clr = 1'b0;
      chk("t4_clr_wins", 32'(drop), 0);
      hit(10'h00F);
      chk("t4_drop_one", 32'(drop), 1);

      // Randomized traffic
      for (int i = 0; i < 400; i++) begin
         arm   = ($urandom % 8) != 0;
         smp   = ($urandom % 2) ? '0 : NPH'($urandom_range(1, 1023));
         ready = ($urandom % 3) == 0;
         clr   = ($urandom % 32) == 0;
         step();
      end
      clr   = 1'b0;
      arm   = 1'b1;
      smp   = '0;
      ready = 1'b0;

      // T5: async reset mid-drain with 7 words stored
      for (int i = 0; i < 16; i++) hit(10'h0FF);
      ready = 1'b1;
      while (m_q.size() > 7) step();
      ready = 1'b0;
      chk("t5_level7", 32'(level), 7);
      #2;
      rst = 1'b0;
      model_reset();
      #1;
      chk("t5_valid", 32'(ts_valid), 0);
      chk("t5_level", 32'(level),    0);
      chk("t5_drop",  32'(drop),     0);
      @(posedge clk);
      #1;
      rst = 1'b1;
      smp = 10'h3F0;
      step();
      smp = '0;
      step();
      chk("t5_restart_coarse", 32'(ts_coarse), 0);
      chk("t5_restart_fine",   32'(ts_fine),   4);

      // T6: 4-bit coarse instance, hit on the wrap cycle
      arm = 1'b0;
      ready = 1'b1;
      @(posedge clk);
      #2;
      rst = 1'b0;
      model_reset();
      @(posedge clk);
      #1;
      rst = 1'b1;
      s_arm = 1'b1;
      repeat (15) step();
      s_smp = 10'h3F0;
      step();
      s_smp = '0;
      repeat (3) step();
      chk("t6_valid",  32'(s_valid),  1);
      chk("t6_coarse", 32'(s_coarse), 15);
      chk("t6_fine",   32'(s_fine),   4);
      chk("t6_marker", 32'(s_marker), 0);
      chk("t6_drop",   32'(s_drop),   0);
`ifdef TDC_ROLLOVER_MARKER_EN
      chk("t6_level", 32'(s_level), 2);
      s_ready = 1'b1;
      step();
      s_ready = 1'b0;
      chk("t6_mrk_coarse", 32'(s_coarse), 0);
      chk("t6_mrk_fine",   32'(s_fine),   0);
      chk("t6_mrk_marker", 32'(s_marker), 1);
`else
      chk("t6_level", 32'(s_level), 1);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
